alu_cu: RTL and testbench
=========================

ALU_CU -- requirements
Module: alu_cu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode request this cycle
- opcode  in  7  instruction[6:0]
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25]
- ALUOp  in  2  main-control class: 00 add, 01 sub/compare, 10 decode funct fields, 11 reserved
- out_valid  out  1  registered copy of in_valid
- alu_op  out  3  ALU operation code
- alu_alt  out  1  alternate-op modifier (SUB instead of ADD, SRA instead of SRL)
- illegal  out  1  unsupported opcode/funct combination

Function
REQ-003 The block SHALL register all outputs with a latency of exactly 1 cycle from the inputs sampled at a rising clk edge.
REQ-004 When in_valid=0, the block SHALL load out_valid=0 and hold alu_op, alu_alt and illegal at their previous values.
REQ-005 The alu_op encoding SHALL be: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-006 With ALUOp=00, the block SHALL output alu_op=000, alu_alt=0, illegal=0, regardless of opcode, func3 and func7.
REQ-007 With ALUOp=01, the block SHALL output alu_op=000, alu_alt=1, illegal=0, regardless of other inputs.
REQ-008 With ALUOp=10 and opcode=0110011 (R-type), the block SHALL output alu_op=func3 and alu_alt=func7[5].
REQ-009 For R-type, func7=0100000 SHALL be legal only with func3=000 or 101; all other func7 values SHALL be illegal except 0000000.
REQ-010 With ALUOp=10 and opcode=0010011 (I-type), the block SHALL output alu_op=func3.
REQ-011 For I-type, alu_alt SHALL be func7[5] only when func3=101, and 0 otherwise; in particular ADDI never yields SUB.
REQ-012 For I-type, func3=001 SHALL require func7=0000000, and func3=101 SHALL require func7 of 0000000 or 0100000; any other func7 on these is illegal.
REQ-013 For I-type with any other func3, func7 SHALL be ignored (it carries immediate bits).
REQ-014 With ALUOp=10 and any other opcode, the block SHALL set illegal=1.
REQ-015 With ALUOp=11, the block SHALL set illegal=1.
REQ-016 Whenever illegal=1, the block SHALL output alu_op=000 and alu_alt=0.
REQ-017 illegal SHALL be valid only when out_valid=1.

Reset
REQ-018 While rst_n=0, the block SHALL immediately force out_valid=0, alu_op=000, alu_alt=0 and illegal=0, independent of clk.
REQ-019 The first registered result SHALL appear on the first rising clk edge after rst_n deasserts with in_valid=1.
REQ-020 Reset asserted mid-operation SHALL discard any pending result.

Structure
REQ-021 A shared package SHALL hold the ALUOp class constants (00/01/10/11), the opcode constants (OP_R=0110011, OP_I=0010011), the eight alu_op codes and the legal func7 constants (0000000, 0100000).
REQ-022 The block SHALL consist of a purely combinational sub-module alu_cu_decode (inputs opcode, func3, func7, ALUOp; outputs alu_op, alu_alt, illegal) plus the output register stage in alu_cu.

Verification
REQ-023 ALUOp=00, opcode=0000011, func3=000, in_valid=1 -> next cycle alu_op=000, alu_alt=0, illegal=0, out_valid=1.
REQ-024 ALUOp=01, opcode=1100011 -> alu_op=000, alu_alt=1, illegal=0.
REQ-025 ALUOp=10, opcode=0110011, sweep func3 000..111 with func7=0000000, then func3=000 and 101 with func7=0100000 -> alu_op=func3; alu_alt=1 only for the 0100000 cases (SUB, SRA); illegal=0 throughout.
REQ-026 ALUOp=10, opcode=0010011, func3=000, func7=0100000 -> alu_op=000, alu_alt=0; same opcode with func3=001, func7=0100000 -> illegal=1, alu_op=000.
REQ-027 ALUOp=11 or (ALUOp=10, opcode=1101111) -> illegal=1; then assert rst_n=0 between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_cu_pkg.sv
// Shared constants for the ALU control unit: main-control classes, opcodes,
// ALU operation codes and the funct7 patterns the decoder accepts.
package alu_cu_pkg;

   typedef enum logic [1:0] {
      ALUOP_ADD    = 2'b00,
      ALUOP_SUB    = 2'b01,
      ALUOP_FUNCT  = 2'b10,
      ALUOP_RSVD   = 2'b11
   } aluop_class_e;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SRL  = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // R-type: the alternate funct7 only exists for SUB and SRA.
   function automatic logic r_legal(input logic [2:0] f3, input logic [6:0] f7);
      return (f7 == F7_BASE) ||
             ((f7 == F7_ALT) && ((f3 == ALU_ADD) || (f3 == ALU_SRL)));
   endfunction

   // I-type: only the shift forms constrain funct7; elsewhere it is immediate data.
   function automatic logic i_legal(input logic [2:0] f3, input logic [6:0] f7);
      if (f3 == ALU_SLL)
         return f7 == F7_BASE;
      else if (f3 == ALU_SRL)
         return (f7 == F7_BASE) || (f7 == F7_ALT);
      else
         return 1'b1;
   endfunction

endpackage

// File: rtl/alu_cu_decode.sv
// Combinational decode of main-control class and funct fields into the
// ALU operation, its alternate modifier and an illegal flag.
module alu_cu_decode
   import alu_cu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic [1:0] ALUOp,
   output logic [2:0] alu_op,
   output logic       alu_alt,
   output logic       illegal
);

   always_comb begin
      alu_op  = ALU_ADD;
      alu_alt = 1'b0;
      illegal = 1'b0;
      case (aluop_class_e'(ALUOp))
         ALUOP_ADD: ;
         ALUOP_SUB: alu_alt = 1'b1;
         ALUOP_FUNCT: begin
            if (opcode == OP_R) begin
               if (r_legal(func3, func7)) begin
                  alu_op  = func3;
                  alu_alt = func7[5];
               end else begin
                  illegal = 1'b1;
               end
            end else if (opcode == OP_I) begin
               if (i_legal(func3, func7)) begin
                  alu_op  = func3;
                  alu_alt = (func3 == ALU_SRL) ? func7[5] : 1'b0;
               end else begin
                  illegal = 1'b1;
               end
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_cu.sv
// ALU control unit: combinational decode followed by a single output
// register stage; results update only on valid requests.
module alu_cu
   import alu_cu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic [1:0] ALUOp,
   output logic       out_valid,
   output logic [2:0] alu_op,
   output logic       alu_alt,
   output logic       illegal
);

   logic [2:0] alu_op_p0;
   logic       alu_alt_p0;
   logic       illegal_p0;

   logic       vld_p1;
   logic [2:0] alu_op_p1;
   logic       alu_alt_p1;
   logic       illegal_p1;

   alu_cu_decode u_decode (
      .opcode  (opcode),
      .func3   (func3),
      .func7   (func7),
      .ALUOp   (ALUOp),
      .alu_op  (alu_op_p0),
      .alu_alt (alu_alt_p0),
      .illegal (illegal_p0)
   );

   // p0 -> p1: output register; decoded fields hold while no request is present
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         alu_op_p1  <= ALU_ADD;
         alu_alt_p1 <= 1'b0;
         illegal_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            alu_op_p1  <= alu_op_p0;
            alu_alt_p1 <= alu_alt_p0;
            illegal_p1 <= illegal_p0;
         end
      end
   end

   assign out_valid = vld_p1;
   assign alu_op    = alu_op_p1;
   assign alu_alt   = alu_alt_p1;
   assign illegal   = illegal_p1;

endmodule

// File: tb/tb_alu_cu.sv
// Directed-vector bench for alu_cu; observed word is {out_valid, alu_op, alu_alt, illegal}.
module tb_alu_cu;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;
   logic [1:0] ALUOp;
   logic       out_valid;
   logic [2:0] alu_op;
   logic       alu_alt;
   logic       illegal;

   int total;
   int bad;

   alu_cu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .opcode    (opcode),
      .func3     (func3),
      .func7     (func7),
      .ALUOp     (ALUOp),
      .out_valid (out_valid),
      .alu_op    (alu_op),
      .alu_alt   (alu_alt),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] obs();
      return {out_valid, alu_op, alu_alt, illegal};
   endfunction

   // drive at falling edge, sample 1 time unit after the next rising edge
   task automatic drive(input logic v, input logic [1:0] a, input logic [6:0] o,
                        input logic [2:0] f3, input logic [6:0] f7);
      @(negedge clk);
      in_valid = v;
      ALUOp    = a;
      opcode   = o;
      func3    = f3;
      func7    = f7;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      ALUOp    = 2'b00;
      opcode   = 7'd0;
      func3    = 3'd0;
      func7    = 7'd0;
      #12;
      chk("reset_state", obs(), 6'b0_000_0_0);
      @(negedge clk);
      rst_n = 1'b1;

      // load (ALUOp=00)
      drive(1, 2'b00, 7'b0000011, 3'b000, 7'b0000000);
      chk("aluop00_add", obs(), 6'b1_000_0_0);
      // branch compare (ALUOp=01), funct fields must be ignored
      drive(1, 2'b01, 7'b1100011, 3'b111, 7'b0100000);
      chk("aluop01_sub", obs(), 6'b1_000_1_0);

      // R-type sweep
      for (int i = 0; i < 8; i++) begin
         drive(1, 2'b10, 7'b0110011, 3'(i), 7'b0000000);
         chk($sformatf("rtype_f3_%0d", i), obs(), {1'b1, 3'(i), 1'b0, 1'b0});
      end
      drive(1, 2'b10, 7'b0110011, 3'b000, 7'b0100000);
      chk("rtype_sub", obs(), 6'b1_000_1_0);
      drive(1, 2'b10, 7'b0110011, 3'b101, 7'b0100000);
      chk("rtype_sra", obs(), 6'b1_101_1_0);
      drive(1, 2'b10, 7'b0110011, 3'b001, 7'b0100000);
      chk("rtype_alt_sll_illegal", obs(), 6'b1_000_0_1);
      drive(1, 2'b10, 7'b0110011, 3'b110, 7'b0000001);
      chk("rtype_f7_other_illegal", obs(), 6'b1_000_0_1);

      // I-type
      drive(1, 2'b10, 7'b0010011, 3'b000, 7'b0100000);
      chk("addi_no_sub", obs(), 6'b1_000_0_0);
      drive(1, 2'b10, 7'b0010011, 3'b001, 7'b0100000);
      chk("slli_bad_f7", obs(), 6'b1_000_0_1);
      drive(1, 2'b10, 7'b0010011, 3'b101, 7'b0100000);
      chk("srai", obs(), 6'b1_101_1_0);
      drive(1, 2'b10, 7'b0010011, 3'b101, 7'b0000001);
      chk("shift_right_bad_f7", obs(), 6'b1_000_0_1);
      drive(1, 2'b10, 7'b0010011, 3'b100, 7'b1111111);
      chk("xori_imm_bits", obs(), 6'b1_100_0_0);
      drive(1, 2'b10, 7'b0010011, 3'b001, 7'b0000000);
      chk("slli_ok", obs(), 6'b1_001_0_0);

      // hold behaviour with in_valid low
      drive(0, 2'b11, 7'b1111111, 3'b111, 7'b1111111);
      chk("hold_fields", obs(), 6'b0_001_0_0);

      // unsupported classes / opcodes
      drive(1, 2'b11, 7'b0110011, 3'b111, 7'b0000000);
      chk("aluop11_illegal", obs(), 6'b1_000_0_1);
      drive(1, 2'b10, 7'b1101111, 3'b010, 7'b0000000);
      chk("jal_opcode_illegal", obs(), 6'b1_000_0_1);

      // asynchronous reset between edges, with a valid request pending
      @(negedge clk);
      in_valid = 1'b1;
      ALUOp    = 2'b10;
      opcode   = 7'b0110011;
      func3    = 3'b111;
      func7    = 7'b0000000;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_now", obs(), 6'b0_000_0_0);
      @(posedge clk);
      #1;
      chk("reset_held_over_edge", obs(), 6'b0_000_0_0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      chk("pending_discarded", obs(), 6'b0_000_0_0);
      drive(1, 2'b10, 7'b0110011, 3'b110, 7'b0000000);
      chk("first_after_reset", obs(), 6'b1_110_0_0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
